// File: rtl/microcode_sequencer.sv
// Microcode sequencer: owns the micro-PC, latches microword fields and computes the next micro-address.
// Optional return stack for CALL/RET is enabled by defining MICRO_STACK_EN.
module microcode_sequencer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SEL_WIDTH   = 2,
    parameter int ALU_WIDTH   = 2,
    parameter int COND_COUNT  = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0,
    localparam int CS_WIDTH   = $clog2(COND_COUNT),
    localparam int WORD_WIDTH = 1 + SEL_WIDTH + ALU_WIDTH + 3 + CS_WIDTH + ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] control_store_address,
    input  logic [WORD_WIDTH-1:0] control_store_data,
    input  logic [COND_COUNT-1:0] conditions,
    input  logic [ADDR_WIDTH-1:0] dispatch_address,
    output logic                  output_enable,
    output logic [SEL_WIDTH-1:0]  output_register_selector,
    output logic [ALU_WIDTH-1:0]  alu_opcode,
    output logic                  microword_valid,
    output logic                  halted,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    localparam int SEL_LSB  = 1;
    localparam int ALU_LSB  = SEL_LSB + SEL_WIDTH;
    localparam int MODE_LSB = ALU_LSB + ALU_WIDTH;
    localparam int COND_LSB = MODE_LSB + 3;
    localparam int NEXT_LSB = COND_LSB + CS_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);

    localparam logic [2:0] M_NEXT = 3'b000;
    localparam logic [2:0] M_JUMP = 3'b001;
    localparam logic [2:0] M_BR_T = 3'b010;
    localparam logic [2:0] M_BR_F = 3'b011;
    localparam logic [2:0] M_DISP = 3'b100;
    localparam logic [2:0] M_CALL = 3'b101;
    localparam logic [2:0] M_RET  = 3'b110;
    localparam logic [2:0] M_HALT = 3'b111;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next, pc_inc;
    logic                  cond_bit;

    logic                  f_oe;
    logic [SEL_WIDTH-1:0]  f_sel;
    logic [ALU_WIDTH-1:0]  f_alu;
    logic [2:0]            f_mode;
    logic [CS_WIDTH-1:0]   f_cond;
    logic [ADDR_WIDTH-1:0] f_next;

    assign f_oe   = control_store_data[0];
    assign f_sel  = control_store_data[SEL_LSB  +: SEL_WIDTH];
    assign f_alu  = control_store_data[ALU_LSB  +: ALU_WIDTH];
    assign f_mode = control_store_data[MODE_LSB +: 3];
    assign f_cond = control_store_data[COND_LSB +: CS_WIDTH];
    assign f_next = control_store_data[NEXT_LSB +: ADDR_WIDTH];

    // Wraps naturally at the top of the address space.
    assign pc_inc                = pc + 1'b1;
    assign control_store_address = pc;
    assign halted                = (state == S_HALT);

    always_comb begin
        cond_bit = conditions[0];
        if (int'(f_cond) < COND_COUNT) cond_bit = conditions[f_cond];
    end

`ifdef MICRO_STACK_EN
    localparam int SP_WIDTH  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_WIDTH-1:0] SP_FULL = SP_WIDTH'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SP_WIDTH-1:0]   sp, top_idx;
    logic                  do_push, do_pop, sp_empty;

    assign sp_empty = (sp == '0);
    assign top_idx  = sp_empty ? '0 : sp - 1'b1;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc_inc;
`ifdef MICRO_STACK_EN
        do_push    = 1'b0;
        do_pop     = 1'b0;
`endif
        if (state == S_HALT) begin
            pc_next = pc;
        end else begin
            case (f_mode)
                M_NEXT: pc_next = pc_inc;
                M_JUMP: pc_next = f_next;
                M_BR_T: pc_next = cond_bit ? f_next : pc_inc;
                M_BR_F: pc_next = cond_bit ? pc_inc : f_next;
                M_DISP: pc_next = dispatch_address;
                M_CALL: begin
                    pc_next = f_next;
`ifdef MICRO_STACK_EN
                    do_push = 1'b1;
`endif
                end
                M_RET: begin
`ifdef MICRO_STACK_EN
                    do_pop  = 1'b1;
                    pc_next = sp_empty ? RESET_PC : stack_mem[top_idx[IDX_WIDTH-1:0]];
`else
                    pc_next = pc_inc;
`endif
                end
                M_HALT: begin
                    pc_next    = pc;
                    state_next = S_HALT;
                end
                default: pc_next = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                    <= S_RUN;
            pc                       <= RESET_PC;
            output_enable            <= 1'b0;
            output_register_selector <= '0;
            alu_opcode               <= '0;
            microword_valid          <= 1'b0;
        end else if (!stall) begin
            state                    <= state_next;
            pc                       <= pc_next;
            output_enable            <= f_oe;
            output_register_selector <= f_sel;
            alu_opcode               <= f_alu;
            microword_valid          <= 1'b1;
        end else begin
            microword_valid          <= 1'b0;
        end
    end

`ifdef MICRO_STACK_EN
    // A push into a full stack is dropped but the CALL target is still taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp              <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
        end else if (!stall) begin
            if (do_push) begin
                if (sp == SP_FULL) begin
                    stack_overflow <= 1'b1;
                end else begin
                    stack_mem[sp[IDX_WIDTH-1:0]] <= pc_inc;
                    sp <= sp + 1'b1;
                end
            end
            if (do_pop) begin
                if (sp_empty) stack_underflow <= 1'b1;
                else          sp <= sp - 1'b1;
            end
        end
    end
`else
    assign stack_overflow  = 1'b0;
    assign stack_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer with a behavioural async-read control store.
// Stack scenario expectations follow MICRO_STACK_EN when it is defined for the build.
module tb_microcode_sequencer;

    localparam logic [2:0] NXT = 3'b000, JMP = 3'b001, BRT = 3'b010, BRF = 3'b011;
    localparam logic [2:0] DSP = 3'b100, CAL = 3'b101, RTN = 3'b110, HLT = 3'b111;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [7:0]  control_store_address;
    logic [17:0] control_store_data;
    logic [3:0]  conditions;
    logic [7:0]  dispatch_address;
    logic        output_enable;
    logic [1:0]  output_register_selector;
    logic [1:0]  alu_opcode;
    logic        microword_valid;
    logic        halted;
    logic        stack_overflow;
    logic        stack_underflow;

    logic [17:0] rom [256];
    int checks = 0;
    int passed = 0;

    assign control_store_data = rom[control_store_address];

    microcode_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .stall                    (stall),
        .control_store_address    (control_store_address),
        .control_store_data       (control_store_data),
        .conditions               (conditions),
        .dispatch_address         (dispatch_address),
        .output_enable            (output_enable),
        .output_register_selector (output_register_selector),
        .alu_opcode               (alu_opcode),
        .microword_valid          (microword_valid),
        .halted                   (halted),
        .stack_overflow           (stack_overflow),
        .stack_underflow          (stack_underflow)
    );

    always #5 clock = ~clock;

    function automatic logic [17:0] mw(input logic oe, input logic [1:0] sel, input logic [1:0] alu,
                                       input logic [2:0] mode, input logic [1:0] cs, input logic [7:0] na);
        return {na, cs, mode, alu, sel, oe};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] a;
        clear_rom();
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            rom[i] = mw(a[0], a[2:1], a[4:3], NXT, 2'd0, 8'd0);
        end
        #1;
        checks++; if (control_store_address !== 8'h00) $display("FAIL reset_pc got %h exp 00", control_store_address); else passed++;
        checks++; if (microword_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", microword_valid); else passed++;
        checks++; if ({halted, stack_overflow, stack_underflow} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {halted, stack_overflow, stack_underflow}); else passed++;
        apply_reset();
        repeat (5) tick();
        checks++; if (control_store_address !== 8'h05) $display("FAIL run_pc got %h exp 05", control_store_address); else passed++;
        checks++; if (output_register_selector !== 2'd2) $display("FAIL run_sel got %0d exp 2", output_register_selector); else passed++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (control_store_address !== 8'h00) $display("FAIL midreset_pc got %h exp 00", control_store_address); else passed++;
        checks++; if ({output_enable, output_register_selector, alu_opcode, microword_valid} !== 6'd0)
            $display("FAIL midreset_fields got %b exp 000000", {output_enable, output_register_selector, alu_opcode, microword_valid}); else passed++;
        @(negedge clock);
        reset = 1'b0;
        tick();
        checks++; if ({control_store_address, microword_valid} !== {8'h01, 1'b1}) $display("FAIL first_fetch got %h/%b exp 01/1", control_store_address, microword_valid); else passed++;
        tick();
        checks++; if ({control_store_address, output_enable} !== {8'h02, 1'b1}) $display("FAIL second_fetch got %h/%b exp 02/1", control_store_address, output_enable); else passed++;
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[8'h00] = mw(1'b0, 2'd0, 2'd0, JMP, 2'd0, 8'hFF);
        rom[8'hFF] = mw(1'b1, 2'd3, 2'd2, NXT, 2'd0, 8'h00);
        apply_reset();
        tick();
        checks++; if (control_store_address !== 8'hFF) $display("FAIL wrap_jump got %h exp ff", control_store_address); else passed++;
        tick();
        checks++; if (control_store_address !== 8'h00) $display("FAIL wrap_pc got %h exp 00", control_store_address); else passed++;
        checks++; if ({output_enable, output_register_selector, alu_opcode} !== 5'b1_11_10)
            $display("FAIL wrap_fields got %b exp 11110", {output_enable, output_register_selector, alu_opcode}); else passed++;
        tick();
        checks++; if ({control_store_address, alu_opcode} !== {8'hFF, 2'd0}) $display("FAIL wrap_again got %h/%0d exp ff/0", control_store_address, alu_opcode); else passed++;
    endtask

    task automatic test_branch();
        logic [2:0]  modes [4] = '{BRT, BRT, BRF, BRF};
        logic [3:0]  conds [4] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
        logic [7:0]  exp_pc[4] = '{8'h40, 8'h11, 8'h11, 8'h40};
        for (int i = 0; i < 4; i++) begin
            clear_rom();
            rom[8'h00] = mw(1'b0, 2'd0, 2'd0, JMP, 2'd0, 8'h10);
            rom[8'h10] = mw(1'b0, 2'd1, 2'd1, modes[i], 2'd2, 8'h40);
            conditions = conds[i];
            apply_reset();
            tick();
            tick();
            checks++; if (control_store_address !== exp_pc[i])
                $display("FAIL branch_%0d got %h exp %h", i, control_store_address, exp_pc[i]); else passed++;
        end
        checks++; if ({output_register_selector, alu_opcode} !== 4'b0101) $display("FAIL branch_fields got %b exp 0101", {output_register_selector, alu_opcode}); else passed++;
        conditions = 4'b0000;
    endtask

    task automatic test_stall();
        clear_rom();
        rom[8'h00] = mw(1'b1, 2'd2, 2'd3, JMP, 2'd0, 8'h20);
        rom[8'h20] = mw(1'b0, 2'd1, 2'd0, NXT, 2'd0, 8'h00);
        apply_reset();
        tick();
        checks++; if ({control_store_address, microword_valid} !== {8'h20, 1'b1}) $display("FAIL stall_pre got %h/%b exp 20/1", control_store_address, microword_valid); else passed++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({control_store_address, output_enable, output_register_selector, alu_opcode, microword_valid} !== {8'h20, 1'b1, 2'd2, 2'd3, 1'b0})
                $display("FAIL stall_hold_%0d got %h/%b%b%b/%b exp 20/11011/0", i, control_store_address, output_enable, output_register_selector, alu_opcode, microword_valid); else passed++;
        end
        stall = 1'b0;
        tick();
        checks++; if ({control_store_address, output_enable, output_register_selector, microword_valid} !== {8'h21, 1'b0, 2'd1, 1'b1})
            $display("FAIL stall_resume got %h/%b/%0d/%b exp 21/0/1/1", control_store_address, output_enable, output_register_selector, microword_valid); else passed++;
    endtask

    task automatic test_stack();
`ifdef MICRO_STACK_EN
        logic [7:0] exp_pc[10] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h31, 8'h21, 8'h11, 8'h01, 8'h00};
`else
        logic [7:0] exp_pc[10] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
`endif
        logic exp_ovf, exp_unf;
        clear_rom();
        rom[8'h00] = mw(1'b0, 2'd0, 2'd0, CAL, 2'd0, 8'h10);
        rom[8'h10] = mw(1'b0, 2'd0, 2'd0, CAL, 2'd0, 8'h20);
        rom[8'h20] = mw(1'b0, 2'd0, 2'd0, CAL, 2'd0, 8'h30);
        rom[8'h30] = mw(1'b0, 2'd0, 2'd0, CAL, 2'd0, 8'h40);
        rom[8'h40] = mw(1'b0, 2'd0, 2'd0, CAL, 2'd0, 8'h50);
        rom[8'h50] = mw(1'b0, 2'd0, 2'd0, RTN, 2'd0, 8'h00);
        rom[8'h31] = mw(1'b0, 2'd0, 2'd0, RTN, 2'd0, 8'h00);
        rom[8'h21] = mw(1'b0, 2'd0, 2'd0, RTN, 2'd0, 8'h00);
        rom[8'h11] = mw(1'b0, 2'd0, 2'd0, RTN, 2'd0, 8'h00);
        rom[8'h01] = mw(1'b0, 2'd0, 2'd0, RTN, 2'd0, 8'h00);
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
`ifdef MICRO_STACK_EN
            exp_ovf = (i >= 4);
            exp_unf = (i >= 9);
`else
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
`endif
            checks++; if ({control_store_address, stack_overflow, stack_underflow} !== {exp_pc[i], exp_ovf, exp_unf})
                $display("FAIL stack_step_%0d got %h/%b%b exp %h/%b%b", i, control_store_address, stack_overflow, stack_underflow, exp_pc[i], exp_ovf, exp_unf); else passed++;
        end
    endtask

    task automatic test_dispatch_halt();
        clear_rom();
        rom[8'h00] = mw(1'b0, 2'd0, 2'd0, DSP, 2'd0, 8'h00);
        rom[8'h7A] = mw(1'b1, 2'd1, 2'd2, HLT, 2'd0, 8'h33);
        dispatch_address = 8'h7A;
        apply_reset();
        tick();
        checks++; if ({control_store_address, halted} !== {8'h7A, 1'b0}) $display("FAIL dispatch got %h/%b exp 7a/0", control_store_address, halted); else passed++;
        tick();
        checks++; if ({control_store_address, halted, output_enable, output_register_selector, alu_opcode} !== {8'h7A, 1'b1, 1'b1, 2'd1, 2'd2})
            $display("FAIL halt_enter got %h/%b/%b%b%b exp 7a/1/10110", control_store_address, halted, output_enable, output_register_selector, alu_opcode); else passed++;
        dispatch_address = 8'h05;
        repeat (3) tick();
        checks++; if ({control_store_address, halted, microword_valid} !== {8'h7A, 1'b1, 1'b1}) $display("FAIL halt_hold got %h/%b/%b exp 7a/1/1", control_store_address, halted, microword_valid); else passed++;
        stall = 1'b1;
        tick();
        checks++; if ({control_store_address, halted, microword_valid} !== {8'h7A, 1'b1, 1'b0}) $display("FAIL halt_stall got %h/%b/%b exp 7a/1/0", control_store_address, halted, microword_valid); else passed++;
        stall = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({control_store_address, halted} !== {8'h00, 1'b0}) $display("FAIL halt_reset got %h/%b exp 00/0", control_store_address, halted); else passed++;
        @(negedge clock);
        reset = 1'b0;
        tick();
        checks++; if (control_store_address !== 8'h05) $display("FAIL halt_exit_dispatch got %h exp 05", control_store_address); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        conditions = 4'b0000;
        dispatch_address = 8'h00;
        test_reset();
        test_wrap();
        test_branch();
        test_stall();
        test_stack();
        test_dispatch_halt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
